// File: rtl/ring_shift_pkg.sv
// Shared definitions for the ring shifter sequencer.
//   state_e      : sequencer states (IDLE/LOAD/ROTATE/DONE)
//   RING_W       : shifter width
//   RING_RST_PAT : shifter/shadow reset contents (odd bits set)
//   rotl()       : rotate-left reference, count taken modulo RING_W
package ring_shift_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ROTATE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int unsigned        RING_W       = 8;
  localparam logic [RING_W-1:0]  RING_RST_PAT = 8'hAA;

  function automatic logic [RING_W-1:0] rotl(input logic [RING_W-1:0] v,
                                             input int unsigned        n);
    int unsigned s;
    s = n % RING_W;
    // s==0 makes the right shift vanish and the left shift return v unchanged
    return (v << s) | (v >> (RING_W - s));
  endfunction

endpackage

// File: rtl/ring_shift_shadow.sv
// Shadow copy of the 8-bit ring shifter. Applies the same step the shifter
// takes on each sh_en cycle so the contents are available in parallel.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   sh_en    : step this cycle
//   sh_load  : 1 = shift sh_in into bit 0, 0 = recirculate MSB into bit 0
//   sh_in    : serial data bit
//   sh_q     : shadow contents (resets to RST_PAT)
module ring_shift_shadow
  import ring_shift_pkg::*;
#(
  parameter int unsigned       WIDTH   = RING_W,
  parameter logic [WIDTH-1:0]  RST_PAT = RING_RST_PAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sh_en,
  input  logic             sh_load,
  input  logic             sh_in,
  output logic [WIDTH-1:0] sh_q
);

  logic [WIDTH-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (sh_en) begin
      sh_d = {sh_q[WIDTH-2:0], (sh_load ? sh_in : sh_q[WIDTH-1])};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= RST_PAT;
    end else begin
      sh_q <= sh_d;
    end
  end

endmodule

// File: rtl/ring_shift_ctrl.sv
// Sequencer for the ring shifter: serially loads a pattern MSB-first, rotates
// it left rot_cnt steps, then pulses done. A shadow register tracks the
// shifter so the result is available in parallel.
//   clk, rst : clock (rising edge), synchronous active-high reset
//   start    : command strobe, accepted only while ready=1
//   pattern  : pattern to load, sampled on accept
//   rot_cnt  : rotate-left steps, sampled on accept
//   abort    : abandon the command in LOAD/ROTATE
//   ready    : idle and able to accept
//   sh_en    : shifter step enable
//   sh_load  : shifter load select (1 = sh_in, 0 = recirculate MSB)
//   sh_in    : serial data bit to the shifter
//   done     : one-cycle completion pulse
//   result   : shadow contents, valid with done, held until next accept
// Optional: define RING_SHIFT_CTRL_STAT_EN to add stat_cnt[15:0], a
// saturating count of completed commands.
module ring_shift_ctrl
  import ring_shift_pkg::*;
#(
  parameter int unsigned       WIDTH   = RING_W,
  parameter int unsigned       CNT_W   = 4,
  parameter logic [WIDTH-1:0]  RST_PAT = RING_RST_PAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] rot_cnt,
  input  logic             abort,
  output logic             ready,
  output logic             sh_en,
  output logic             sh_load,
  output logic             sh_in,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef RING_SHIFT_CTRL_STAT_EN
  ,
  output logic [15:0]      stat_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic             ready_q, ready_d;
  logic             sh_en_q, sh_en_d;
  logic             sh_load_q, sh_load_d;
  logic             sh_in_q, sh_in_d;
  logic             done_q, done_d;

  // Outputs are registered from the current state, so each shifter step is
  // presented one cycle after the state that issues it. ready is held low
  // through the done pulse so done and ready never overlap.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    sh_en_d   = 1'b0;
    sh_load_d = 1'b0;
    sh_in_d   = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && ready_q) begin
          pat_d   = pattern;
          cnt_d   = rot_cnt;
          idx_d   = IDX_W'(WIDTH-1);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          idx_d   = IDX_W'(WIDTH-1);
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          sh_en_d   = 1'b1;
          sh_load_d = 1'b1;
          sh_in_d   = pat_q[idx_q];
          idx_d     = idx_q - IDX_W'(1);
          if (idx_q == '0) begin
            idx_d   = IDX_W'(WIDTH-1);
            state_d = (cnt_q != '0) ? ROTATE : DONE;
          end
        end
      end
      ROTATE: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          sh_en_d = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) && !done_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= IDX_W'(WIDTH-1);
      cnt_q     <= '0;
      pat_q     <= '0;
      ready_q   <= 1'b1;
      sh_en_q   <= 1'b0;
      sh_load_q <= 1'b0;
      sh_in_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      ready_q   <= ready_d;
      sh_en_q   <= sh_en_d;
      sh_load_q <= sh_load_d;
      sh_in_q   <= sh_in_d;
      done_q    <= done_d;
    end
  end

  assign ready   = ready_q;
  assign sh_en   = sh_en_q;
  assign sh_load = sh_load_q;
  assign sh_in   = sh_in_q;
  assign done    = done_q;

  ring_shift_shadow #(
    .WIDTH   (WIDTH),
    .RST_PAT (RST_PAT)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .sh_en   (sh_en_q),
    .sh_load (sh_load_q),
    .sh_in   (sh_in_q),
    .sh_q    (result)
  );

`ifdef RING_SHIFT_CTRL_STAT_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (done_d && (stat_q != '1)) begin
      stat_d = stat_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt = stat_q;
`endif

endmodule

// File: tb/tb_ring_shift_ctrl.sv
module tb_ring_shift_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] rot_cnt;
  logic       abort;
  logic       ready;
  logic       sh_en;
  logic       sh_load;
  logic       sh_in;
  logic       done;
  logic [7:0] result;
`ifdef RING_SHIFT_CTRL_STAT_EN
  logic [15:0] stat_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Independent model of the external shifter, stepped from the DUT controls.
  logic [7:0] model_sh = 8'hAA;

  ring_shift_ctrl #(
    .WIDTH   (8),
    .CNT_W   (4),
    .RST_PAT (8'hAA)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .rot_cnt (rot_cnt),
    .abort   (abort),
    .ready   (ready),
    .sh_en   (sh_en),
    .sh_load (sh_load),
    .sh_in   (sh_in),
    .done    (done),
    .result  (result)
`ifdef RING_SHIFT_CTRL_STAT_EN
    ,
    .stat_cnt(stat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) model_sh <= 8'hAA;
    else if (sh_en) model_sh <= sh_load ? {model_sh[6:0], sh_in} : {model_sh[6:0], model_sh[7]};
  end

  // Drives one command and waits (bounded) for done; lat=-1 on timeout.
  task automatic do_cmd(input logic [7:0] pat, input logic [3:0] rc,
                        output int lat, output logic [7:0] res);
    pattern = pat;
    rot_cnt = rc;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    res = 8'hxx;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || sh_en !== 1'b0 || sh_load !== 1'b0 || sh_in !== 1'b0)
      begin errors++; $display("FAIL reset_ctrl got rdy=%b done=%b en=%b ld=%b in=%b want 1 0 0 0 0",
                               ready, done, sh_en, sh_load, sh_in); end
    checks++;
    if (result !== 8'hAA) begin errors++; $display("FAIL reset_result got %h want aa", result); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [7:0] bits;
    bits    = 8'hB4;
    pattern = 8'hB4;
    rot_cnt = 4'd3;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (ready !== 1'b0 || sh_en !== 1'b0)
      begin errors++; $display("FAIL accept got rdy=%b en=%b want 0 0", ready, sh_en); end
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      checks++;
      if (k <= 8) begin
        if (sh_en !== 1'b1 || sh_load !== 1'b1 || sh_in !== bits[8-k] || done !== 1'b0)
          begin errors++; $display("FAIL load_bit k=%0d got en=%b ld=%b in=%b done=%b want 1 1 %b 0",
                                   k, sh_en, sh_load, sh_in, done, bits[8-k]); end
      end else if (k <= 11) begin
        if (sh_en !== 1'b1 || sh_load !== 1'b0 || sh_in !== 1'b0 || done !== 1'b0)
          begin errors++; $display("FAIL rotate k=%0d got en=%b ld=%b in=%b done=%b want 1 0 0 0",
                                   k, sh_en, sh_load, sh_in, done); end
      end else if (k == 12) begin
        if (done !== 1'b1 || sh_en !== 1'b0 || ready !== 1'b0 || result !== 8'hA5)
          begin errors++; $display("FAIL done_basic got done=%b en=%b rdy=%b res=%h want 1 0 0 a5",
                                   done, sh_en, ready, result); end
      end else begin
        if (done !== 1'b0 || ready !== 1'b1 || result !== 8'hA5)
          begin errors++; $display("FAIL after_done got done=%b rdy=%b res=%h want 0 1 a5",
                                   done, ready, result); end
      end
    end
  endtask

  task automatic test_rot_edges;
    int lat;
    logic [7:0] res;
    do_cmd(8'h3C, 4'd0, lat, res);
    checks++;
    if (lat != 9 || res !== 8'h3C)
      begin errors++; $display("FAIL rot_zero got lat=%0d res=%h want 9 3c", lat, res); end
    @(posedge clk); #1;
    do_cmd(8'h81, 4'd9, lat, res);
    checks++;
    if (lat != 18 || res !== 8'h03)
      begin errors++; $display("FAIL rot_wrap got lat=%0d res=%h want 18 03", lat, res); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort;
    int seen_done;
    int lat;
    // Prior result is 8'h03; four bits of F0 (1111) get shifted in -> 8'h3F.
    pattern = 8'hF0;
    rot_cnt = 4'd2;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (ready !== 1'b1 || sh_en !== 1'b0)
      begin errors++; $display("FAIL abort_idle got rdy=%b en=%b want 1 0", ready, sh_en); end
    seen_done = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", seen_done); end
    checks++;
    if (result !== 8'h3F) begin errors++; $display("FAIL abort_partial got %h want 3f", result); end

    // Second start during ROTATE must be ignored.
    pattern = 8'h0F;
    rot_cnt = 4'd5;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (k == 10) begin
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", ready); end
        pattern = 8'hFF;
        rot_cnt = 4'd1;
        start   = 1'b1;
      end
      if (done === 1'b1) begin lat = k; break; end
    end
    start = 1'b0;
    checks++;
    if (lat != 14 || result !== 8'hE1)
      begin errors++; $display("FAIL ignore_start got lat=%0d res=%h want 14 e1", lat, result); end
    seen_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (sh_en !== 1'b0) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin errors++; $display("FAIL no_second_cmd got %0d steps want 0", seen_done); end
  endtask

  task automatic test_reset_mid;
    int lat;
    int bad;
    pattern = 8'h5A;
    rot_cnt = 4'd6;
    start   = 1'b1;
    bad     = 0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (result !== model_sh) bad++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || sh_en !== 1'b0 || sh_load !== 1'b0 || sh_in !== 1'b0 || result !== 8'hAA)
      begin errors++; $display("FAIL rst_mid got rdy=%b done=%b en=%b ld=%b in=%b res=%h want 1 0 0 0 0 aa",
                               ready, done, sh_en, sh_load, sh_in, result); end
    pattern = 8'hC3;
    rot_cnt = 4'd2;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (result !== model_sh) bad++;
      if (done === 1'b1) begin lat = k; break; end
    end
    checks++;
    if (lat != 11 || result !== 8'h0F)
      begin errors++; $display("FAIL after_rst_cmd got lat=%0d res=%h want 11 0f", lat, result); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL shadow_model got %0d diverging cycles want 0", bad); end
  endtask

`ifdef RING_SHIFT_CTRL_STAT_EN
  task automatic test_stat;
    int lat;
    logic [7:0] res;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (stat_cnt !== 16'd0) begin errors++; $display("FAIL stat_reset got %0d want 0", stat_cnt); end
    do_cmd(8'h12, 4'd1, lat, res);
    do_cmd(8'h34, 4'd0, lat, res);
    @(posedge clk); #1;
    pattern = 8'h56;
    rot_cnt = 4'd2;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    do_cmd(8'h78, 4'd3, lat, res);
    @(posedge clk); #1;
    checks++;
    if (stat_cnt !== 16'd3) begin errors++; $display("FAIL stat_count got %0d want 3", stat_cnt); end
    dut.stat_q = 16'hFFFE;
    do_cmd(8'h9A, 4'd1, lat, res);
    @(posedge clk); #1;
    do_cmd(8'hBC, 4'd1, lat, res);
    @(posedge clk); #1;
    checks++;
    if (stat_cnt !== 16'hFFFF) begin errors++; $display("FAIL stat_saturate got %h want ffff", stat_cnt); end
  endtask
`endif

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    pattern = 8'h00;
    rot_cnt = 4'd0;
    abort   = 1'b0;
    test_reset();
    test_basic();
    test_rot_edges();
    test_abort();
    test_reset_mid();
`ifdef RING_SHIFT_CTRL_STAT_EN
    test_stat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
